// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master.
// Holds the FSM state type, the mode constants and the counter-width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETUP      = 3'd1,
        XFER       = 3'd2,
        HOLD       = 3'd3,
        BURST_WAIT = 3'd4,
        GAP        = 3'd5
    } state_e;

    localparam logic CPOL      = 1'b0;
    localparam logic CPHA      = 1'b0;
    localparam logic IDLE_MOSI = 1'b1;

    // Wide enough to hold the largest of the timing counts, inclusive.
    function automatic int cnt_width(input int clk_div, input int cs_setup,
                                     input int cs_hold, input int cs_gap);
        int m;
        m = clk_div;
        m = (cs_setup > m) ? cs_setup : m;
        m = (cs_hold  > m) ? cs_hold  : m;
        m = (cs_gap   > m) ? cs_gap   : m;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_master_tx_sck_gen.sv
// SCK generator: a phase counter that toggles SCK every CLK_DIV cycles while enabled.
// The ticks mark the clock edge on which SCK is about to rise or fall.
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int CW      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [CW-1:0] PHASE_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PHASE_ONE  = CW'(1);

    logic [CW-1:0] phase_q;
    logic [CW-1:0] phase_d;
    logic          sck_q;
    logic          sck_d;
    logic          term_s;

    // Next phase and SCK level; disabling parks SCK at its idle level.
    always_comb begin
        term_s    = (phase_q == PHASE_LAST);
        rise_tick = en & term_s & ~sck_q;
        fall_tick = en & term_s & sck_q;
        if (!en) begin
            phase_d = {CW{1'b0}};
            sck_d   = CPOL;
        end else if (term_s) begin
            phase_d = {CW{1'b0}};
            sck_d   = ~sck_q;
        end else begin
            phase_d = phase_q + PHASE_ONE;
            sck_d   = sck_q;
        end
    end

    // Phase and SCK registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= {CW{1'b0}};
            sck_q   <= CPOL;
        end else begin
            phase_q <= phase_d;
            sck_q   <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master, MSB first, full duplex, with single-word frames and
// multi-word bursts held under one CS assertion.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int SIZE_WORD = 8,
    parameter int CLK_DIV   = 8,
    parameter int CS_SETUP  = 4,
    parameter int CS_HOLD   = 4,
    parameter int CS_GAP    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SIZE_WORD-1:0] tx_data,
    input  logic                 tx_hold_cs,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [SIZE_WORD-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 SCK,
    output logic                 CS,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int CW = cnt_width(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP);
    localparam int BW = $clog2(SIZE_WORD);

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
    localparam logic [BW-1:0] BIT_ONE    = BW'(1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(SIZE_WORD - 1);

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [SIZE_WORD-1:0]   tx_sr_q, tx_sr_d;
    logic [SIZE_WORD-1:0]   rx_sr_q, rx_sr_d;
    logic [SIZE_WORD-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   hold_cs_q, hold_cs_d;
    logic                   cs_q, cs_d;
    logic                   mosi_q, mosi_d;
    logic                   busy_q, busy_d;
    logic                   miso_meta_q, miso_sync_q;
    logic                   accept_s;
    logic                   sck_en_s;
    logic                   sck_s;
    logic                   rise_tick_s;
    logic                   fall_tick_s;

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV),
        .CW      (CW)
    ) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (sck_en_s),
        .sck       (sck_s),
        .rise_tick (rise_tick_s),
        .fall_tick (fall_tick_s)
    );

    // Handshake decode; only IDLE and BURST_WAIT take a new word.
    always_comb begin
        tx_ready = ((state_q == IDLE) || (state_q == BURST_WAIT)) & ~rst;
        accept_s = tx_valid & tx_ready;
        sck_en_s = (state_q == XFER);
    end

    // Frame sequencing: next state, shift registers, counters and pin levels.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        hold_cs_d  = hold_cs_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d   = SETUP;
                    cs_d      = 1'b0;
                    tx_sr_d   = tx_data;
                    mosi_d    = tx_data[SIZE_WORD-1];
                    hold_cs_d = tx_hold_cs;
                    cnt_d     = {CW{1'b0}};
                    bit_cnt_d = {BW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = XFER;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            XFER: begin
                if (rise_tick_s) begin
                    rx_sr_d = {rx_sr_q[SIZE_WORD-2:0], miso_sync_q};
                end else if (fall_tick_s) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d    = HOLD;
                        rx_data_d  = rx_sr_q;
                        rx_valid_d = 1'b1;
                        cnt_d      = {CW{1'b0}};
                    end else begin
                        // Rotating keeps every bit of tx_sr live; MOSI takes the next bit down.
                        tx_sr_d   = {tx_sr_q[SIZE_WORD-2:0], tx_sr_q[SIZE_WORD-1]};
                        mosi_d    = tx_sr_q[SIZE_WORD-2];
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    state_d = XFER;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = {CW{1'b0}};
                    if (hold_cs_q) begin
                        state_d = BURST_WAIT;
                    end else begin
                        state_d = GAP;
                        cs_d    = 1'b1;
                        mosi_d  = IDLE_MOSI;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            BURST_WAIT: begin
                if (accept_s) begin
                    state_d   = XFER;
                    tx_sr_d   = tx_data;
                    mosi_d    = tx_data[SIZE_WORD-1];
                    hold_cs_d = tx_hold_cs;
                    bit_cnt_d = {BW{1'b0}};
                end else begin
                    state_d = BURST_WAIT;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                mosi_d  = IDLE_MOSI;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers; reset drops any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            bit_cnt_q   <= {BW{1'b0}};
            tx_sr_q     <= {SIZE_WORD{1'b0}};
            rx_sr_q     <= {SIZE_WORD{1'b0}};
            rx_data_q   <= {SIZE_WORD{1'b0}};
            rx_valid_q  <= 1'b0;
            hold_cs_q   <= 1'b0;
            cs_q        <= 1'b1;
            mosi_q      <= IDLE_MOSI;
            busy_q      <= 1'b0;
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            hold_cs_q   <= hold_cs_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            miso_meta_q <= MISO;
            miso_sync_q <= miso_meta_q;
        end
    end

    assign SCK      = sck_s;
    assign CS       = cs_q;
    assign MOSI     = mosi_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx: loopback and a behavioural mode-0 slave,
// with expectations taken from word bits and frame timing arithmetic.
module tb_spi_master_tx;

    localparam int SW      = 8;
    localparam int DIV     = 8;
    localparam int SETUP_C = 4;
    localparam int HOLD_C  = 4;
    localparam int GAP_C   = 4;
    localparam int FRAME   = 1 + SETUP_C + 2 * SW * DIV + HOLD_C;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] tx_data = '0;
    logic          tx_hold_cs = 1'b0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [SW-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          sck_w, cs_w, mosi_w, miso_w;

    logic          loopback = 1'b1;
    logic [SW-1:0] slave_word = '0;
    logic [SW-1:0] slave_sr = '0;
    logic [SW-1:0] slave_rx = '0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    spi_master_tx #(
        .SIZE_WORD (SW), .CLK_DIV (DIV), .CS_SETUP (SETUP_C),
        .CS_HOLD (HOLD_C), .CS_GAP (GAP_C)
    ) dut (
        .clk (clk), .rst (rst), .tx_data (tx_data), .tx_hold_cs (tx_hold_cs),
        .tx_valid (tx_valid), .tx_ready (tx_ready), .rx_data (rx_data),
        .rx_valid (rx_valid), .busy (busy), .SCK (sck_w), .CS (cs_w),
        .MOSI (mosi_w), .MISO (miso_w)
    );

    assign miso_w = loopback ? mosi_w : slave_sr[SW-1];

    // Behavioural mode-0 slave: presents MSB at CS fall, samples on rise, shifts on fall.
    always @(negedge cs_w) slave_sr = slave_word;
    always @(posedge sck_w) if (!cs_w) slave_rx = {slave_rx[SW-2:0], mosi_w};
    always @(negedge sck_w) if (!cs_w) slave_sr = {slave_sr[SW-2:0], 1'b0};

    // Bus monitor, sampled on the falling clk edge.
    int            cyc = 0;
    int            rise_cyc[$];
    logic          mosi_bits[$];
    logic [SW-1:0] rx_q[$];
    int            cs_runs[$];
    int            widths[$];
    int            cs_run = 0, sck_run = 0;
    int            cs_rise_cyc = 0, ready_rise_cyc = 0;
    int            mosi_viol = 0, rxv_viol = 0;
    logic          prev_sck = 1'b0, prev_mosi = 1'b1, prev_cs = 1'b1;
    logic          prev_ready = 1'b0, prev_rxv = 1'b0, had_rise = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sck_w && !prev_sck) begin
            rise_cyc.push_back(cyc);
            mosi_bits.push_back(mosi_w);
        end
        if (sck_w !== prev_sck) begin
            if (prev_sck || had_rise) widths.push_back(sck_run);
            sck_run <= 1;
        end else begin
            sck_run <= sck_run + 1;
        end
        if (cs_w) had_rise <= 1'b0;
        else if (sck_w && !prev_sck) had_rise <= 1'b1;
        if (sck_w && prev_sck && (mosi_w !== prev_mosi)) mosi_viol <= mosi_viol + 1;
        if (!cs_w) begin
            cs_run <= cs_run + 1;
        end else if (!prev_cs) begin
            cs_runs.push_back(cs_run);
            cs_run <= 0;
            cs_rise_cyc <= cyc;
        end
        if (tx_ready && !prev_ready) ready_rise_cyc <= cyc;
        if (rx_valid) rx_q.push_back(rx_data);
        if (rx_valid && prev_rxv) rxv_viol <= rxv_viol + 1;
        prev_sck   <= sck_w;
        prev_mosi  <= mosi_w;
        prev_cs    <= cs_w;
        prev_ready <= tx_ready;
        prev_rxv   <= rx_valid;
    end

    task automatic clear_mon();
        @(negedge clk);
        #1;
        rise_cyc.delete();
        mosi_bits.delete();
        rx_q.delete();
        cs_runs.delete();
        widths.delete();
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send(input logic [SW-1:0] d, input logic h);
        bit ok;
        wait_ready(ok);
        n_total++;
        if (!ok) $display("FAIL send_ready: tx_ready=%b, required 1 within 2000 cycles", tx_ready);
        else n_pass++;
        tx_data    = d;
        tx_hold_cs = h;
        tx_valid   = 1'b1;
        @(negedge clk);
        tx_valid   = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        n_total++;
        if (!ok) $display("FAIL wait_idle: busy=%b tx_ready=%b, required idle within 3000 cycles", busy, tx_ready);
        else n_pass++;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++;
        if ({cs_w, sck_w, mosi_w, rx_valid, busy, tx_ready} !== 6'b101000)
            $display("FAIL reset_pins: cs,sck,mosi,rxv,busy,rdy=%b, required 101000",
                     {cs_w, sck_w, mosi_w, rx_valid, busy, tx_ready});
        else n_pass++;
        n_total++;
        if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h, required 00", rx_data);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (tx_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release: tx_ready=%b busy=%b, required 1 0", tx_ready, busy);
        else n_pass++;
    endtask

    task automatic test_loopback();
        logic [SW-1:0] d;
        logic [SW-1:0] got;
        loopback = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d = (k == 0) ? 8'hA5 : 8'($urandom);
            clear_mon();
            send(d, 1'b0);
            wait_idle();
            got = '0;
            foreach (mosi_bits[i]) got = {got[SW-2:0], mosi_bits[i]};
            n_total++;
            if (mosi_bits.size() != SW || got !== d)
                $display("FAIL lb_mosi_bits: %0d bits value %h, required %0d bits value %h", mosi_bits.size(), got, SW, d);
            else n_pass++;
            for (int i = 1; i < rise_cyc.size(); i++) begin
                n_total++;
                if (rise_cyc[i] - rise_cyc[i-1] != 2 * DIV)
                    $display("FAIL lb_rise_spacing: %0d, required %0d", rise_cyc[i] - rise_cyc[i-1], 2 * DIV);
                else n_pass++;
            end
            n_total++;
            if (rx_q.size() != 1) $display("FAIL lb_rx_count: %0d pulses, required 1", rx_q.size());
            else if (rx_q[0] !== d) $display("FAIL lb_rx_data: %h, required %h", rx_q[0], d);
            else n_pass++;
            n_total++;
            if (cs_runs.size() != 1) $display("FAIL lb_cs_frames: %0d, required 1", cs_runs.size());
            else if (cs_runs[0] != FRAME) $display("FAIL lb_cs_low: %0d cycles, required %0d", cs_runs[0], FRAME);
            else n_pass++;
            n_total++;
            if (ready_rise_cyc - cs_rise_cyc != GAP_C)
                $display("FAIL lb_cs_gap: %0d cycles, required %0d", ready_rise_cyc - cs_rise_cyc, GAP_C);
            else n_pass++;
        end
    endtask

    task automatic test_slave();
        logic [SW-1:0] d;
        logic [SW-1:0] sw;
        loopback = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d  = (k == 0) ? 8'h81 : 8'($urandom);
            sw = (k == 0) ? 8'h3C : 8'($urandom);
            slave_word = sw;
            clear_mon();
            send(d, 1'b0);
            wait_idle();
            n_total++;
            if (slave_rx !== d) $display("FAIL slave_rx: %h, required %h", slave_rx, d);
            else n_pass++;
            n_total++;
            if (rx_q.size() != 1) $display("FAIL slave_rx_count: %0d pulses, required 1", rx_q.size());
            else if (rx_q[0] !== sw) $display("FAIL slave_miso_data: %h, required %h", rx_q[0], sw);
            else n_pass++;
        end
        loopback = 1'b1;
    endtask

    task automatic test_burst();
        logic [SW-1:0] w[3];
        logic [3*SW-1:0] exp_bits;
        logic [3*SW-1:0] got;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) w[i] = (k == 0) ? 8'(8'h11 * (i + 1)) : 8'($urandom);
            exp_bits = {w[0], w[1], w[2]};
            clear_mon();
            send(w[0], 1'b1);
            send(w[1], 1'b1);
            send(w[2], 1'b0);
            wait_idle();
            n_total++;
            if (cs_runs.size() != 1) $display("FAIL burst_cs_frames: %0d, required 1", cs_runs.size());
            else n_pass++;
            n_total++;
            if (rx_q.size() != 3) $display("FAIL burst_rx_count: %0d, required 3", rx_q.size());
            else if (rx_q[0] !== w[0] || rx_q[1] !== w[1] || rx_q[2] !== w[2])
                $display("FAIL burst_rx_data: %h %h %h, required %h %h %h", rx_q[0], rx_q[1], rx_q[2], w[0], w[1], w[2]);
            else n_pass++;
            got = '0;
            foreach (mosi_bits[i]) got = {got[3*SW-2:0], mosi_bits[i]};
            n_total++;
            if (mosi_bits.size() != 3 * SW || got !== exp_bits)
                $display("FAIL burst_mosi: %0d bits %h, required %0d bits %h", mosi_bits.size(), got, 3 * SW, exp_bits);
            else n_pass++;
        end
    endtask

    task automatic test_burst_wait();
        logic [SW-1:0] w0, w1;
        int viol = 0;
        bit ok;
        w0 = 8'($urandom);
        w1 = 8'($urandom);
        clear_mon();
        send(w0, 1'b1);
        wait_ready(ok);
        n_total++;
        if (!ok || cs_w !== 1'b0) $display("FAIL bw_enter: ready=%b cs=%b, required 1 0", tx_ready, cs_w);
        else n_pass++;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cs_w !== 1'b0 || sck_w !== 1'b0 || tx_ready !== 1'b1) viol++;
        end
        n_total++;
        if (viol != 0) $display("FAIL bw_hold: %0d bad cycles, required 0", viol);
        else n_pass++;
        send(w1, 1'b0);
        wait_idle();
        n_total++;
        if (rx_q.size() != 2) $display("FAIL bw_rx_count: %0d, required 2", rx_q.size());
        else if (rx_q[0] !== w0 || rx_q[1] !== w1)
            $display("FAIL bw_rx_data: %h %h, required %h %h", rx_q[0], rx_q[1], w0, w1);
        else n_pass++;
        n_total++;
        if (cs_runs.size() != 1) $display("FAIL bw_cs_frames: %0d, required 1", cs_runs.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        clear_mon();
        send(8'($urandom), 1'b0);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (rise_cyc.size() == 4) begin
                ok = 1'b1;
                break;
            end
        end
        n_total++;
        if (!ok) $display("FAIL rm_fourth_rise: %0d rises, required 4", rise_cyc.size());
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({cs_w, sck_w, mosi_w, rx_valid, busy} !== 5'b10100)
            $display("FAIL rm_pins: cs,sck,mosi,rxv,busy=%b, required 10100", {cs_w, sck_w, mosi_w, rx_valid, busy});
        else n_pass++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if (rx_q.size() != 0) $display("FAIL rm_no_rx: %0d pulses, required 0", rx_q.size());
        else n_pass++;
        clear_mon();
        send(8'h5A, 1'b0);
        wait_idle();
        n_total++;
        if (rx_q.size() != 1) $display("FAIL rm_post_count: %0d, required 1", rx_q.size());
        else if (rx_q[0] !== 8'h5A) $display("FAIL rm_post_data: %h, required 5a", rx_q[0]);
        else n_pass++;
        n_total++;
        if (cs_runs.size() != 1 || cs_runs[0] != FRAME)
            $display("FAIL rm_post_cs: %0d frames, required 1 of %0d cycles", cs_runs.size(), FRAME);
        else n_pass++;
    endtask

    task automatic test_hold_valid();
        int n = 0;
        int bad_w = 0;
        bit ok;
        clear_mon();
        tx_data    = 8'($urandom);
        tx_hold_cs = 1'b0;
        wait_ready(ok);
        tx_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            n++;
            if (tx_ready === 1'b1) break;
        end
        tx_valid = 1'b0;
        n_total++;
        if (n != FRAME + GAP_C + 1)
            $display("FAIL hv_next_ready: %0d cycles, required %0d", n, FRAME + GAP_C + 1);
        else n_pass++;
        n_total++;
        if (rx_q.size() != 1 || rx_q[0] !== tx_data)
            $display("FAIL hv_single_word: %0d words, required 1 of %h", rx_q.size(), tx_data);
        else n_pass++;
        foreach (widths[i]) if (widths[i] != DIV) bad_w++;
        n_total++;
        if (widths.size() != 2 * SW - 1 || bad_w != 0)
            $display("FAIL hv_sck_widths: %0d widths %0d wrong, required %0d all %0d", widths.size(), bad_w, 2 * SW - 1, DIV);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL hv_no_reaccept: busy=%b, required 0", busy);
        else n_pass++;
        n_total++;
        if (mosi_viol != 0 || rxv_viol != 0)
            $display("FAIL protocol: mosi changes while SCK high %0d, long rx_valid %0d, required 0 0", mosi_viol, rxv_viol);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_slave();
        test_burst();
        test_burst_wait();
        test_reset_mid();
        test_hold_valid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
